// File: rtl/pal_sync_analyzer_pkg.sv
// Shared timing constants for the PAL/NTSC sync generator and analyzer:
// mode encodings, per-mode line/frame totals and the timing classifier.
package pal_sync_analyzer_pkg;

  localparam logic [1:0] MODE_48K  = 2'b00;
  localparam logic [1:0] MODE_128K = 2'b01;
  localparam logic [1:0] MODE_PENT = 2'b10;
  localparam logic [1:0] MODE_NTSC = 2'b11;

  // Clken ticks per line.
  localparam logic [9:0] LINE_48K  = 10'd448;
  localparam logic [9:0] LINE_128K = 10'd456;
  localparam logic [9:0] LINE_PENT = 10'd448;
  localparam logic [9:0] LINE_NTSC = 10'd448;

  // Lines per frame.
  localparam logic [8:0] FRAME_48K  = 9'd312;
  localparam logic [8:0] FRAME_128K = 9'd311;
  localparam logic [8:0] FRAME_PENT = 9'd320;
  localparam logic [8:0] FRAME_NTSC = 9'd262;

  // Bit 2 set marks a frame that matches no known timing.
  localparam logic [2:0] CLASS_INVALID = 3'b100;

  typedef struct packed {
    logic [9:0] len;
    logic [8:0] lines;
  } timing_t;

  // Indexed by mode encoding.
  typedef timing_t [3:0] timing_tab_t;

  localparam timing_tab_t TIMING_DEFAULT = {
    LINE_NTSC, FRAME_NTSC,
    LINE_PENT, FRAME_PENT,
    LINE_128K, FRAME_128K,
    LINE_48K,  FRAME_48K
  };

  // Map a (line length, frame lines) pair to a mode; lowest index wins.
  function automatic logic [2:0] classify(input logic [9:0] len,
                                          input logic [8:0] lines,
                                          input logic ok,
                                          input timing_tab_t tab);
    logic [2:0] cls;
    cls = CLASS_INVALID;
    for (int i = 3; i >= 0; i--) begin
      if (ok && (tab[i].len == len) && (tab[i].lines == lines)) begin
        cls = {1'b0, 2'(i)};
      end
    end
    return cls;
  endfunction

endpackage

// File: rtl/pal_sync_analyzer_sync_edge_counter.sv
// Falling-edge detector on an active-low sync, a saturating position counter
// cleared by that edge, and a capture of the period that the edge completes.
module sync_edge_counter #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clken,
  input  logic              sync_n,
  input  logic              inc,
  output logic              fall,
  output logic [DATA_W-1:0] pos,
  output logic [DATA_W-1:0] period,
  output logic              at_max
);

  logic prev;

  assign fall   = clken & prev & ~sync_n;
  assign at_max = &pos;

  // Edge history, position count and completed-period capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev   <= 1'b1;
      pos    <= '0;
      period <= '0;
    end else if (clken) begin
      prev <= sync_n;
      if (fall) begin
        period <= pos + DATA_W'(inc);
        pos    <= '0;
      end else if (inc && !at_max) begin
        pos <= pos + DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/pal_sync_analyzer.sv
// Receive-side sync analyzer: measures line length and frame height from an
// active-low hsync/vsync pair, classifies the timing and reports lock.
module pal_sync_analyzer
  import pal_sync_analyzer_pkg::*;
#(
  parameter int          LOCK_FRAMES = 2,
  parameter int          HTIMEOUT    = 1023,
  parameter timing_tab_t TIMING      = TIMING_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       hsync_n,
  input  logic       vsync_n,
  output logic [9:0] hpos,
  output logic [8:0] vpos,
  output logic [9:0] line_len,
  output logic [8:0] frame_lines,
  output logic [1:0] mode,
  output logic       locked
);

  localparam int CNT_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_FRAMES);
  localparam logic [9:0] HT_M1 = 10'(HTIMEOUT - 1);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic hfall, vfall, h_max, vpos_max;

  sync_edge_counter #(.DATA_W(10)) u_hcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clken  (clken),
    .sync_n (hsync_n),
    .inc    (1'b1),
    .fall   (hfall),
    .pos    (hpos),
    .period (line_len),
    .at_max (h_max)
  );

  sync_edge_counter #(.DATA_W(9)) u_vcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clken  (clken),
    .sync_n (vsync_n),
    .inc    (hfall),
    .fall   (vfall),
    .pos    (vpos),
    .period (frame_lines),
    .at_max (vpos_max)
  );

  logic [1:0]       state;
  logic [1:0]       cand;
  logic [CNT_W-1:0] count;
  logic [9:0]       ref_len;
  logic             ref_valid;
  logic             line_ok;

  logic [9:0]       len_now;
  logic [8:0]       lines_now;
  logic             len_mismatch;
  logic             ok_now;
  logic [9:0]       ref_now;
  logic [2:0]       cls;
  logic [CNT_W-1:0] cnt_new;
  logic             timeout;

  // Frame verdict as seen at this tick, including the line an hfall closes now.
  always_comb begin
    len_now      = hpos + 10'd1;
    lines_now    = vpos + {8'd0, hfall};
    len_mismatch = hfall & ref_valid & (len_now != ref_len);
    ok_now       = line_ok & ~len_mismatch & ~vpos_max;
    ref_now      = (hfall & ~ref_valid) ? len_now : ref_len;
    cls          = classify(ref_now, lines_now, ok_now & (ref_valid | hfall), TIMING);
    cnt_new      = (cls[1:0] == cand) ? count + CNT_W'(1) : CNT_W'(1);
    timeout      = ~hfall & (h_max | (hpos >= HT_M1));
  end

  // Per-frame line-length consistency; the reference is the frame's first line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_len   <= '0;
      ref_valid <= 1'b0;
      line_ok   <= 1'b0;
    end else if (clken) begin
      if (vfall) begin
        line_ok   <= 1'b1;
        ref_valid <= 1'b0;
      end else begin
        line_ok <= ok_now;
        if (hfall && !ref_valid) begin
          ref_len   <= len_now;
          ref_valid <= 1'b1;
        end
      end
    end
  end

  // Search / measure / locked decision, taken at each vsync falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_SEARCH;
      cand   <= MODE_48K;
      count  <= '0;
      mode   <= MODE_48K;
      locked <= 1'b0;
    end else if (clken) begin
      if (timeout) begin
        state  <= ST_SEARCH;
        locked <= 1'b0;
        count  <= '0;
      end else if (vfall) begin
        case (state)
          ST_SEARCH: begin
            state <= ST_MEASURE;
            count <= '0;
          end
          ST_MEASURE: begin
            if (cls[2]) begin
              count <= '0;
            end else begin
              cand  <= cls[1:0];
              count <= cnt_new;
              if (cnt_new == LOCK_CNT) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
                mode   <= cls[1:0];
              end
            end
          end
          ST_LOCKED: begin
            if (cls != {1'b0, mode}) begin
              state  <= ST_MEASURE;
              locked <= 1'b0;
              count  <= '0;
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pal_sync_analyzer.sv
// Bench for pal_sync_analyzer: a scaled-down sync generator drives the DUT,
// a frame-level reference model predicts every output each cycle, and
// directed checks pin the expected lock sequence.
module tb_pal_sync_analyzer;

  localparam int LOCK_FRAMES = 2;
  localparam int HTIMEOUT    = 1023;

  // Short timings so several frames fit in a short run: {len, lines} per mode 3..0.
  localparam pal_sync_analyzer_pkg::timing_tab_t TB_TIMING =
    {10'd20, 9'd9, 10'd20, 9'd14, 10'd24, 9'd11, 10'd20, 9'd12};
  int tl [4] = '{20, 24, 20, 20};
  int tf [4] = '{12, 11, 14, 9};

  logic       clk = 1'b0;
  logic       rst_n, clken, hsync_n, vsync_n;
  logic [9:0] hpos, line_len;
  logic [8:0] vpos, frame_lines;
  logic [1:0] mode;
  logic       locked;

  pal_sync_analyzer #(
    .LOCK_FRAMES (LOCK_FRAMES),
    .HTIMEOUT    (HTIMEOUT),
    .TIMING      (TB_TIMING)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clken       (clken),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .hpos        (hpos),
    .vpos        (vpos),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .mode        (mode),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_hpos, m_vpos, m_line_len, m_frame_lines, m_mode, m_locked;
  int m_prev_h, m_prev_v, m_searching, m_streak_cls, m_streak_n;
  int m_sat, m_vfalls = 0;
  int lens[$];
  bit model_valid = 0;

  function automatic int model_class(input int lines);
    if (lens.size() == 0 || m_sat != 0) return 4;
    foreach (lens[i]) if (lens[i] != lens[0]) return 4;
    for (int i = 0; i < 4; i++) if (tl[i] == lens[0] && tf[i] == lines) return i;
    return 4;
  endfunction

  always @(posedge clk) begin
    int hf, vf, new_h, tmo, cls;
    if (!rst_n) begin
      m_hpos = 0; m_vpos = 0; m_line_len = 0; m_frame_lines = 0;
      m_mode = 0; m_locked = 0; m_prev_h = 1; m_prev_v = 1;
      m_searching = 1; m_streak_cls = 0; m_streak_n = 0; m_sat = 0;
      lens.delete();
      model_valid = 1;
    end else if (clken) begin
      hf = (m_prev_h == 1 && hsync_n == 1'b0) ? 1 : 0;
      vf = (m_prev_v == 1 && vsync_n == 1'b0) ? 1 : 0;
      if (m_vpos == 511) m_sat = 1;
      new_h = hf ? 0 : (m_hpos < 1023 ? m_hpos + 1 : 1023);
      tmo = (hf == 0 && new_h >= HTIMEOUT) ? 1 : 0;
      if (hf) begin
        m_line_len = (m_hpos + 1) % 1024;
        lens.push_back(m_line_len);
      end
      if (vf) begin
        m_vfalls++;
        m_frame_lines = (m_vpos + hf) % 512;
        cls = model_class(m_frame_lines);
        lens.delete();
        m_sat = 0;
        if (!tmo) begin
          if (m_searching) begin
            m_searching = 0; m_streak_n = 0;
          end else if (m_locked) begin
            if (cls != m_mode) begin m_locked = 0; m_streak_n = 0; end
          end else if (cls == 4) begin
            m_streak_n = 0;
          end else begin
            if (cls == m_streak_cls) m_streak_n++;
            else begin m_streak_cls = cls; m_streak_n = 1; end
            if (m_streak_n == LOCK_FRAMES) begin m_locked = 1; m_mode = cls; end
          end
        end
      end
      if (tmo) begin m_searching = 1; m_locked = 0; m_streak_n = 0; end
      if (vf) m_vpos = 0;
      else if (hf && m_vpos < 511) m_vpos = m_vpos + 1;
      m_hpos = new_h;
      m_prev_h = int'(hsync_n);
      m_prev_v = int'(vsync_n);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("hpos", int'(hpos), m_hpos);
      check("vpos", int'(vpos), m_vpos);
      check("line_len", int'(line_len), m_line_len);
      check("frame_lines", int'(frame_lines), m_frame_lines);
      check("locked", int'(locked), m_locked);
      if (m_locked != 0) check("mode", int'(mode), m_mode);
    end
  end

  // ---------------- stimulus generator ----------------
  int g_h, g_v, g_len, g_lines, nxt_len, nxt_lines;
  bit hold = 0, gaps = 0, short_on = 0;

  task automatic set_mode(input int m);
    nxt_len = tl[m];
    nxt_lines = tf[m];
  endtask

  task automatic step();
    int cur_len;
    hsync_n = hold ? 1'b1 : (g_h >= 4);
    vsync_n = hold ? 1'b1 : (g_v >= 2);
    clken   = gaps ? ($urandom_range(0, 9) < 7) : 1'b1;
    if (clken) begin
      cur_len = (short_on && g_v == 5) ? g_len - 8 : g_len;
      g_h++;
      if (g_h >= cur_len) begin
        g_h = 0;
        g_v++;
        if (g_v >= g_lines) begin
          g_v = 0; g_len = nxt_len; g_lines = nxt_lines; short_on = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vfalls(input int n, input string name);
    int target;
    int guard;
    target = m_vfalls + n;
    guard = 0;
    while (m_vfalls < target && guard < 4000) begin
      step();
      guard++;
    end
    if (m_vfalls < target) begin
      tests++;
      fails++;
      $display("FAIL %s: saw %0d vsync edges, required %0d", name, m_vfalls, target);
    end
  endtask

  initial begin
    int lk;
    int guard;
    rst_n = 1'b0; clken = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1;
    set_mode(0);
    g_len = nxt_len; g_lines = nxt_lines; g_h = 0; g_v = 5;

    // Real-size timing table in the shared package.
    check("pkg_48k",  int'(pal_sync_analyzer_pkg::classify(10'd448, 9'd312, 1'b1, pal_sync_analyzer_pkg::TIMING_DEFAULT)), 0);
    check("pkg_128k", int'(pal_sync_analyzer_pkg::classify(10'd456, 9'd311, 1'b1, pal_sync_analyzer_pkg::TIMING_DEFAULT)), 1);
    check("pkg_pent", int'(pal_sync_analyzer_pkg::classify(10'd448, 9'd320, 1'b1, pal_sync_analyzer_pkg::TIMING_DEFAULT)), 2);
    check("pkg_ntsc", int'(pal_sync_analyzer_pkg::classify(10'd448, 9'd262, 1'b1, pal_sync_analyzer_pkg::TIMING_DEFAULT)), 3);
    check("pkg_bad_len", int'(pal_sync_analyzer_pkg::classify(10'd440, 9'd312, 1'b1, pal_sync_analyzer_pkg::TIMING_DEFAULT)), 4);
    check("pkg_not_ok", int'(pal_sync_analyzer_pkg::classify(10'd448, 9'd312, 1'b0, pal_sync_analyzer_pkg::TIMING_DEFAULT)), 4);

    repeat (3) @(posedge clk);
    #1;
    check("rst_hpos", int'(hpos), 0);
    check("rst_vpos", int'(vpos), 0);
    check("rst_line_len", int'(line_len), 0);
    check("rst_frame_lines", int'(frame_lines), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_locked", int'(locked), 0);
    rst_n = 1'b1;

    // 48K: partial frame, then two good frames to lock.
    wait_vfalls(2, "48k_pre");
    check("48k_not_yet", int'(locked), 0);
    wait_vfalls(1, "48k_lock");
    check("48k_locked", int'(locked), 1);
    check("48k_mode", int'(mode), 0);
    check("48k_line_len", int'(line_len), 20);
    check("48k_frame_lines", int'(frame_lines), 12);

    // Switch to 128K at the next frame boundary.
    set_mode(1);
    wait_vfalls(1, "128k_last48");
    check("128k_still_locked", int'(locked), 1);
    wait_vfalls(1, "128k_first");
    check("128k_unlock", int'(locked), 0);
    check("128k_frame_lines", int'(frame_lines), 11);
    wait_vfalls(1, "128k_cnt1");
    check("128k_cnt1", int'(locked), 0);
    wait_vfalls(1, "128k_lock");
    check("128k_locked", int'(locked), 1);
    check("128k_mode", int'(mode), 1);
    check("128k_line_len", int'(line_len), 24);

    // Pentagon.
    set_mode(2);
    wait_vfalls(2, "pent_first");
    check("pent_unlock", int'(locked), 0);
    check("pent_frame_lines", int'(frame_lines), 14);
    wait_vfalls(2, "pent_lock");
    check("pent_locked", int'(locked), 1);
    check("pent_mode", int'(mode), 2);

    // NTSC.
    set_mode(3);
    wait_vfalls(2, "ntsc_first");
    check("ntsc_unlock", int'(locked), 0);
    check("ntsc_frame_lines", int'(frame_lines), 9);
    wait_vfalls(2, "ntsc_lock");
    check("ntsc_locked", int'(locked), 1);
    check("ntsc_mode", int'(mode), 3);

    // One short line breaks the frame; a second one resets the count again.
    short_on = 1;
    wait_vfalls(1, "short1");
    check("short_unlock", int'(locked), 0);
    wait_vfalls(1, "short_cnt1");
    check("short_cnt1", int'(locked), 0);
    short_on = 1;
    wait_vfalls(1, "short2");
    check("short2_invalid", int'(locked), 0);
    wait_vfalls(1, "short2_cnt1");
    check("short2_cnt1", int'(locked), 0);
    wait_vfalls(1, "short_relock");
    check("short_relock", int'(locked), 1);
    check("short_relock_mode", int'(mode), 3);

    // Sync loss: lock drops on the edge where hpos reaches 1023.
    hold = 1;
    lk = 0;
    guard = 0;
    while (m_hpos != 1023 && guard < 2000) begin
      lk = int'(locked);
      step();
      guard++;
    end
    check("tmo_hpos", int'(hpos), 1023);
    check("tmo_locked", int'(locked), 0);
    check("tmo_locked_before", lk, 1);
    repeat (5) step();
    check("tmo_hpos_hold", int'(hpos), 1023);
    check("tmo_still_unlocked", int'(locked), 0);
    guard = 0;
    while (g_v != 5 && guard < 400) begin step(); guard++; end
    hold = 0;
    wait_vfalls(2, "tmo_recover");
    check("tmo_recover_cnt", int'(locked), 0);
    wait_vfalls(1, "tmo_relock");
    check("tmo_relock", int'(locked), 1);
    check("tmo_relock_mode", int'(mode), 3);

    // Reset mid-frame while locked.
    repeat (50) step();
    check("pre_rst_locked", int'(locked), 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_hpos", int'(hpos), 0);
    check("mid_rst_vpos", int'(vpos), 0);
    check("mid_rst_line_len", int'(line_len), 0);
    check("mid_rst_frame_lines", int'(frame_lines), 0);
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_locked", int'(locked), 0);
    rst_n = 1'b1;
    wait_vfalls(2, "rst_recover");
    check("rst_recover_cnt", int'(locked), 0);
    wait_vfalls(1, "rst_relock");
    check("rst_relock", int'(locked), 1);
    check("rst_relock_mode", int'(mode), 3);

    // Sparse pixel enable must not disturb a locked NTSC stream.
    gaps = 1;
    wait_vfalls(3, "gaps");
    gaps = 0;
    check("gaps_locked", int'(locked), 1);
    check("gaps_mode", int'(mode), 3);
    check("gaps_line_len", int'(line_len), 20);
    check("gaps_frame_lines", int'(frame_lines), 9);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
